// File: rtl/eth_test_pkg.sv
// Shared definitions for the Ethernet loopback test-pattern blocks.
// Holds the test ethertypes, the payload info-field layout, the error-flag
// bit indices and the checker state encoding.
package eth_test_pkg;

  localparam logic [15:0] ETH_TYPE_TEST = 16'h88B6;
  localparam logic [15:0] ETH_TYPE_DATA = 16'h88B5;

  localparam int unsigned MAC_W  = 48;
  localparam int unsigned TYPE_W = 16;
  localparam int unsigned DATA_W = 8;

  // Info field at the head of every test payload (byte offsets, big-endian)
  localparam int unsigned SEQ_OFS  = 0;
  localparam int unsigned TS_OFS   = 4;
  localparam int unsigned INFO_LEN = 8;

  // Error flag bit indices
  localparam int unsigned ERR_PATTERN = 0;
  localparam int unsigned ERR_LENGTH  = 1;
  localparam int unsigned ERR_SEQ     = 2;
  localparam int unsigned ERR_TUSER   = 3;
  localparam int unsigned ERR_SHORT   = 4;
  localparam int unsigned ERR_W       = 5;

  localparam int unsigned IDX_W = 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DROP  = 2'd2
  } state_e;

endpackage

// File: rtl/eth_pattern_checker_if.sv
// Decoded Ethernet header plus AXI-stream payload, as produced by eth_axis_rx.
// master: frame source (drives header/payload, receives readies)
// slave : frame sink   (receives header/payload, drives readies)
interface eth_pattern_checker_if;
  import eth_test_pkg::*;

  logic              s_eth_hdr_valid;
  logic              s_eth_hdr_ready;
  logic [MAC_W-1:0]  s_eth_dest_mac;
  logic [MAC_W-1:0]  s_eth_src_mac;
  logic [TYPE_W-1:0] s_eth_type;
  logic [DATA_W-1:0] s_eth_payload_axis_tdata;
  logic              s_eth_payload_axis_tvalid;
  logic              s_eth_payload_axis_tready;
  logic              s_eth_payload_axis_tlast;
  logic              s_eth_payload_axis_tuser;

  modport master (
    output s_eth_hdr_valid, s_eth_dest_mac, s_eth_src_mac, s_eth_type,
           s_eth_payload_axis_tdata, s_eth_payload_axis_tvalid,
           s_eth_payload_axis_tlast, s_eth_payload_axis_tuser,
    input  s_eth_hdr_ready, s_eth_payload_axis_tready
  );

  modport slave (
    input  s_eth_hdr_valid, s_eth_dest_mac, s_eth_src_mac, s_eth_type,
           s_eth_payload_axis_tdata, s_eth_payload_axis_tvalid,
           s_eth_payload_axis_tlast, s_eth_payload_axis_tuser,
    output s_eth_hdr_ready, s_eth_payload_axis_tready
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones once reached.
// Ports: clk, rst_n (sync, active-low), inc_i (count enable), count_o (value).
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/eth_pattern_checker.sv
// Receive-side loopback test-pattern checker.
// Filters test frames by MAC/ethertype, checks sequence, payload pattern and
// length, measures round-trip latency and keeps saturating frame counters and
// sticky, individually clearable error flags.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   enable            accept test frames (others drained as dropped)
//   local_mac/peer_mac required dest/src MAC
//   timestamp         free-running microsecond count
//   s_eth             header + payload stream (slave side)
//   good/bad/dropped_frames  saturating counters
//   last/max_latency  latency of last checked frame / maximum since reset
//   error_flags       sticky flags, error_clears per-bit clear
module eth_pattern_checker
  import eth_test_pkg::*;
#(
  parameter int unsigned       PAYLOAD_LENGTH = 56,
  parameter logic [TYPE_W-1:0] ETH_TYPE       = ETH_TYPE_TEST,
  parameter int unsigned       TS_WIDTH       = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [MAC_W-1:0]    local_mac,
  input  logic [MAC_W-1:0]    peer_mac,
  input  logic [TS_WIDTH-1:0] timestamp,
  eth_pattern_checker_if.slave s_eth,
  output logic [31:0]         good_frames,
  output logic [31:0]         bad_frames,
  output logic [31:0]         dropped_frames,
  output logic [TS_WIDTH-1:0] last_latency,
  output logic [TS_WIDTH-1:0] max_latency,
  output logic [ERR_W-1:0]    error_flags,
  input  logic [ERR_W-1:0]    error_clears
);

  localparam int unsigned INFO_W = INFO_LEN * DATA_W;
  localparam int unsigned CNT_W  = IDX_W + 1;
  localparam int unsigned SEQ_HI = INFO_W - 1 - DATA_W * SEQ_OFS;
  localparam int unsigned TS_HI  = INFO_W - 1 - DATA_W * TS_OFS;

  state_e              state_q, state_d;
  logic                hdr_ready_q, hdr_ready_d;
  logic                tready_q, tready_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [INFO_W-1:0]   info_q, info_d;
  logic                pat_err_q, pat_err_d;
  logic [31:0]         exp_seq_q, exp_seq_d;
  logic                exp_valid_q, exp_valid_d;
  logic [ERR_W-1:0]    flags_q, flags_d;
  logic                good_inc_q, good_inc_d;
  logic                bad_inc_q, bad_inc_d;
  logic                drop_inc_q, drop_inc_d;
  logic                lat_upd_q, lat_upd_d;
  logic [TS_WIDTH-1:0] lat_q, lat_d;
  logic [TS_WIDTH-1:0] last_lat_q, last_lat_d;
  logic [TS_WIDTH-1:0] max_lat_q, max_lat_d;

  logic                hdr_fire_c;
  logic                beat_c;
  logic                frame_match_c;
  logic [CNT_W-1:0]    count_c;
  logic [INFO_W-1:0]   info_now_c;
  logic [DATA_W-1:0]   exp_byte_c;
  logic                byte_err_c;
  logic                short_c;
  logic [31:0]         seq_c;
  logic [TS_WIDTH-1:0] lat_c;
  logic [ERR_W-1:0]    set_c;

  // Handshakes, filter and per-beat datapath terms
  always_comb begin
    hdr_fire_c    = s_eth.s_eth_hdr_valid && hdr_ready_q;
    beat_c        = s_eth.s_eth_payload_axis_tvalid && tready_q;
    frame_match_c = enable && (s_eth.s_eth_dest_mac == local_mac) &&
                    (s_eth.s_eth_src_mac == peer_mac) && (s_eth.s_eth_type == ETH_TYPE);
    count_c       = CNT_W'(idx_q) + CNT_W'(1);
    // Info bytes shift in big-endian; includes the current beat so a frame
    // ending exactly on byte 7 is evaluated with its complete info field.
    info_now_c    = (idx_q < IDX_W'(INFO_LEN)) ?
                    {info_q[INFO_W-DATA_W-1:0], s_eth.s_eth_payload_axis_tdata} : info_q;
    exp_byte_c    = info_q[SEQ_HI-24 -: DATA_W] + idx_q[DATA_W-1:0];
    byte_err_c    = (idx_q >= IDX_W'(INFO_LEN)) &&
                    (s_eth.s_eth_payload_axis_tdata != exp_byte_c);
    short_c       = count_c < CNT_W'(INFO_LEN);
    seq_c         = info_now_c[SEQ_HI -: 32];
    // Modular subtraction absorbs timestamp wrap-around
    lat_c         = timestamp - TS_WIDTH'(info_now_c[TS_HI -: 32]);
  end

  // Next-state, frame evaluation and register next values
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    info_d      = info_q;
    pat_err_d   = pat_err_q;
    exp_seq_d   = exp_seq_q;
    exp_valid_d = exp_valid_q;
    set_c       = '0;
    good_inc_d  = 1'b0;
    bad_inc_d   = 1'b0;
    drop_inc_d  = 1'b0;
    lat_upd_d   = 1'b0;
    lat_d       = lat_q;

    unique case (state_q)
      ST_IDLE: begin
        if (hdr_fire_c) begin
          state_d   = frame_match_c ? ST_CHECK : ST_DROP;
          idx_d     = '0;
          pat_err_d = 1'b0;
        end
      end
      ST_CHECK: begin
        if (beat_c) begin
          if (idx_q != {IDX_W{1'b1}}) idx_d = idx_q + IDX_W'(1);
          info_d = info_now_c;
          if (byte_err_c) pat_err_d = 1'b1;
          if (s_eth.s_eth_payload_axis_tlast) begin
            state_d               = ST_IDLE;
            set_c[ERR_SHORT]      = short_c;
            set_c[ERR_LENGTH]     = count_c != CNT_W'(PAYLOAD_LENGTH);
            set_c[ERR_PATTERN]    = pat_err_q || byte_err_c;
            set_c[ERR_TUSER]      = s_eth.s_eth_payload_axis_tuser;
            if (!short_c) begin
              set_c[ERR_SEQ] = exp_valid_q && (seq_c != exp_seq_q);
              exp_seq_d      = seq_c + 32'd1;
              exp_valid_d    = 1'b1;
              if (!s_eth.s_eth_payload_axis_tuser) begin
                lat_upd_d = 1'b1;
                lat_d     = lat_c;
              end
            end
            if (set_c != '0) bad_inc_d  = 1'b1;
            else             good_inc_d = 1'b1;
          end
        end
      end
      ST_DROP: begin
        if (beat_c && s_eth.s_eth_payload_axis_tlast) begin
          state_d    = ST_IDLE;
          drop_inc_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Set beats clear on the same bit
    flags_d = (flags_q & ~error_clears) | set_c;

    last_lat_d = last_lat_q;
    max_lat_d  = max_lat_q;
    if (lat_upd_q) begin
      last_lat_d = lat_q;
      if (lat_q > max_lat_q) max_lat_d = lat_q;
    end

    hdr_ready_d = (state_d == ST_IDLE);
    tready_d    = (state_d != ST_IDLE);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hdr_ready_q <= 1'b0;
      tready_q    <= 1'b0;
      idx_q       <= '0;
      info_q      <= '0;
      pat_err_q   <= 1'b0;
      exp_seq_q   <= '0;
      exp_valid_q <= 1'b0;
      flags_q     <= '0;
      good_inc_q  <= 1'b0;
      bad_inc_q   <= 1'b0;
      drop_inc_q  <= 1'b0;
      lat_upd_q   <= 1'b0;
      lat_q       <= '0;
      last_lat_q  <= '0;
      max_lat_q   <= '0;
    end else begin
      hdr_ready_q <= hdr_ready_d;
      tready_q    <= tready_d;
      idx_q       <= idx_d;
      info_q      <= info_d;
      pat_err_q   <= pat_err_d;
      exp_seq_q   <= exp_seq_d;
      exp_valid_q <= exp_valid_d;
      flags_q     <= flags_d;
      good_inc_q  <= good_inc_d;
      bad_inc_q   <= bad_inc_d;
      drop_inc_q  <= drop_inc_d;
      lat_upd_q   <= lat_upd_d;
      lat_q       <= lat_d;
      last_lat_q  <= last_lat_d;
      max_lat_q   <= max_lat_d;
    end
  end

  sat_counter #(.WIDTH(32)) u_good_cnt (
    .clk(clk), .rst_n(rst_n), .inc_i(good_inc_q), .count_o(good_frames)
  );
  sat_counter #(.WIDTH(32)) u_bad_cnt (
    .clk(clk), .rst_n(rst_n), .inc_i(bad_inc_q), .count_o(bad_frames)
  );
  sat_counter #(.WIDTH(32)) u_drop_cnt (
    .clk(clk), .rst_n(rst_n), .inc_i(drop_inc_q), .count_o(dropped_frames)
  );

  assign s_eth.s_eth_hdr_ready           = hdr_ready_q;
  assign s_eth.s_eth_payload_axis_tready = tready_q;
  assign last_latency                    = last_lat_q;
  assign max_latency                     = max_lat_q;
  assign error_flags                     = flags_q;

endmodule

// File: tb/tb_eth_pattern_checker.sv
// Self-checking bench for eth_pattern_checker: directed scenarios plus
// randomized frames scored against a frame-level reference model.
module tb_eth_pattern_checker;
  import eth_test_pkg::*;

  localparam int unsigned PLEN = 56;
  localparam int unsigned TSW  = 24;
  localparam logic [47:0] LMAC = 48'h02_00_00_00_00_01;
  localparam logic [47:0] PMAC = 48'h02_00_00_00_00_02;

  typedef logic [7:0] byteq_t[$];

  logic           clk = 1'b0;
  logic           rst_n;
  logic           enable;
  logic [TSW-1:0] ts;
  logic [31:0]    good_frames, bad_frames, dropped_frames;
  logic [TSW-1:0] last_latency, max_latency;
  logic [4:0]     error_flags, error_clears;

  eth_pattern_checker_if bus();

  eth_pattern_checker #(.PAYLOAD_LENGTH(PLEN), .ETH_TYPE(16'h88B6), .TS_WIDTH(TSW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .local_mac(LMAC), .peer_mac(PMAC),
    .timestamp(ts), .s_eth(bus), .good_frames(good_frames), .bad_frames(bad_frames),
    .dropped_frames(dropped_frames), .last_latency(last_latency), .max_latency(max_latency),
    .error_flags(error_flags), .error_clears(error_clears)
  );

  always #4 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0]    m_good, m_bad, m_drop, m_exp;
  bit             m_exp_valid;
  logic [TSW-1:0] m_last, m_max;
  logic [4:0]     m_flags;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic byteq_t make_payload(input logic [31:0] seq, input logic [31:0] txts,
                                          input int len);
    byteq_t p;
    for (int i = 0; i < len; i++) begin
      if (i < 4)      p.push_back(seq[31-8*i -: 8]);
      else if (i < 8) p.push_back(txts[31-8*(i-4) -: 8]);
      else            p.push_back(8'((seq & 32'hFF) + 32'(i)));
    end
    return p;
  endfunction

  task automatic model_reset();
    m_good = 0; m_bad = 0; m_drop = 0; m_exp = 0; m_exp_valid = 0;
    m_last = 0; m_max = 0; m_flags = 0;
  endtask

  // Frame-level outcome computed from the payload bytes alone
  task automatic model_frame(input bit accept, input byteq_t p, input bit tu,
                             input logic [TSW-1:0] ts_now, input logic [4:0] clr);
    logic [4:0]  set;
    logic [31:0] seq, txts;
    int          n;
    set = '0;
    n   = p.size();
    if (!accept) begin
      if (m_drop != 32'hFFFF_FFFF) m_drop++;
    end else begin
      if (n < 8) set[4] = 1'b1;
      if (n != PLEN) set[1] = 1'b1;
      if (tu) set[3] = 1'b1;
      if (n >= 8) begin
        seq  = {p[0], p[1], p[2], p[3]};
        txts = {p[4], p[5], p[6], p[7]};
        for (int i = 8; i < n; i++)
          if (p[i] != 8'((seq + 32'(i)) % 256)) set[0] = 1'b1;
        if (m_exp_valid && seq != m_exp) set[2] = 1'b1;
        m_exp = seq + 1;
        m_exp_valid = 1;
        if (!tu) begin
          m_last = ts_now - txts[TSW-1:0];
          if (m_last > m_max) m_max = m_last;
        end
      end
      if (set != 0) begin if (m_bad  != 32'hFFFF_FFFF) m_bad++;  end
      else          begin if (m_good != 32'hFFFF_FFFF) m_good++; end
    end
    m_flags = (m_flags & ~clr) | set;
  endtask

  task automatic idle_bus();
    bus.s_eth_hdr_valid = 0; bus.s_eth_dest_mac = '0; bus.s_eth_src_mac = '0;
    bus.s_eth_type = '0; bus.s_eth_payload_axis_tdata = '0;
    bus.s_eth_payload_axis_tvalid = 0; bus.s_eth_payload_axis_tlast = 0;
    bus.s_eth_payload_axis_tuser = 0; error_clears = '0;
  endtask

  // Returns early (stream left idle) when beat abort_at is reached
  task automatic send_frame(input logic [47:0] dmac, input logic [47:0] smac,
                            input logic [15:0] etype, input byteq_t p, input bit tu,
                            input logic [4:0] clr, input int abort_at);
    bit hs;
    int guard, stalls;
    bus.s_eth_dest_mac = dmac; bus.s_eth_src_mac = smac; bus.s_eth_type = etype;
    bus.s_eth_hdr_valid = 1;
    guard = 0;
    do begin
      @(negedge clk); hs = bus.s_eth_hdr_ready; @(posedge clk); #1; guard++;
    end while (!hs && guard < 200);
    bus.s_eth_hdr_valid = 0;
    if (!hs) begin check_val("hdr_timeout", 0, 1); return; end
    stalls = 0;
    for (int i = 0; i < p.size(); i++) begin
      if (i == abort_at) begin idle_bus(); return; end
      while ($urandom_range(0, 3) == 0) begin
        bus.s_eth_payload_axis_tvalid = 0; @(posedge clk); #1;
      end
      bus.s_eth_payload_axis_tdata  = p[i];
      bus.s_eth_payload_axis_tvalid = 1;
      bus.s_eth_payload_axis_tlast  = (i == p.size() - 1);
      bus.s_eth_payload_axis_tuser  = (i == p.size() - 1) ? tu : 1'($urandom);
      error_clears = (i == p.size() - 1) ? clr : 5'b0;
      guard = 0;
      do begin
        @(negedge clk); hs = bus.s_eth_payload_axis_tready;
        if (!hs) stalls++;
        @(posedge clk); #1; guard++;
      end while (!hs && guard < 200);
      if (!hs) begin check_val("beat_timeout", 0, 1); idle_bus(); return; end
    end
    idle_bus();
    check_val("tready_stall", 64'(stalls), 0);
  endtask

  task automatic compare_all(input string tag);
    check_val({tag, ".good"}, good_frames, m_good);
    check_val({tag, ".bad"}, bad_frames, m_bad);
    check_val({tag, ".drop"}, dropped_frames, m_drop);
    check_val({tag, ".last_lat"}, last_latency, m_last);
    check_val({tag, ".max_lat"}, max_latency, m_max);
    check_val({tag, ".flags"}, error_flags, m_flags);
  endtask

  task automatic run_frame(input string tag, input logic [47:0] dmac, input logic [47:0] smac,
                           input logic [15:0] etype, input bit en, input byteq_t p,
                           input bit tu, input logic [4:0] clr);
    bit accept;
    enable = en;
    accept = en && dmac == LMAC && smac == PMAC && etype == 16'h88B6;
    model_frame(accept, p, tu, ts, clr);
    send_frame(dmac, smac, etype, p, tu, clr, -1);
    repeat (3) @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset();
    idle_bus();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst.hdr_ready", bus.s_eth_hdr_ready, 0);
    check_val("rst.tready", bus.s_eth_payload_axis_tready, 0);
    model_reset();
    compare_all("rst");
    rst_n = 1;
    @(posedge clk); #1;
    check_val("post_rst.hdr_ready", bus.s_eth_hdr_ready, 1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    byteq_t p;
    logic [4:0] clr;
    rst_n = 0; enable = 1; ts = 24'd1000;
    idle_bus();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // Good frames with 40 us latency
    for (int s = 5; s <= 7; s++)
      run_frame("good", LMAC, PMAC, 16'h88B6, 1, make_payload(32'(s), 32'd960, PLEN), 0, 0);
    check_val("plan.good3", good_frames, 3);
    check_val("plan.lat40", last_latency, 40);

    // Sequence gap then resync
    do_reset();
    run_frame("seq10", LMAC, PMAC, 16'h88B6, 1, make_payload(10, 32'd960, PLEN), 0, 0);
    run_frame("seq12", LMAC, PMAC, 16'h88B6, 1, make_payload(12, 32'd960, PLEN), 0, 0);
    check_val("plan.seqflag", error_flags[2], 1);
    run_frame("seq13", LMAC, PMAC, 16'h88B6, 1, make_payload(13, 32'd960, PLEN), 0, 0);
    check_val("plan.seq13good", good_frames, 2);

    // Corrupted byte 20, then clear the pattern flag
    do_reset();
    p = make_payload(20, 32'd960, PLEN);
    p[20] = p[20] ^ 8'h01;
    run_frame("corrupt", LMAC, PMAC, 16'h88B6, 1, p, 0, 0);
    check_val("plan.patflag", error_flags[0], 1);
    error_clears = 5'b00001; @(posedge clk); #1; error_clears = 5'b0;
    m_flags = m_flags & ~5'b00001;
    @(posedge clk); #1;
    compare_all("clear");

    // Set and clear on the same bit in the tlast cycle: set wins
    p = make_payload(21, 32'd960, PLEN);
    p[30] = p[30] ^ 8'h80;
    run_frame("setwins", LMAC, PMAC, 16'h88B6, 1, p, 0, 5'b00001);

    // Non-matching frames drained
    do_reset();
    run_frame("drop_type", LMAC, PMAC, 16'h0800, 1, make_payload(1, 0, PLEN), 0, 0);
    run_frame("drop_src", LMAC, 48'hDEAD_BEEF_0000, 16'h88B6, 1, make_payload(2, 0, PLEN), 0, 0);
    run_frame("drop_en", LMAC, PMAC, 16'h88B6, 0, make_payload(3, 0, PLEN), 0, 0);
    check_val("plan.drop3", dropped_frames, 3);

    // Latency across timestamp wrap, then a short frame
    enable = 1;
    ts = 24'h000010;
    run_frame("wrap", LMAC, PMAC, 16'h88B6, 1, make_payload(40, 32'hAB_FFFFF0, PLEN), 0, 0);
    check_val("plan.lat_wrap", last_latency, 24'h20);
    p = make_payload(41, 32'd0, 6);
    run_frame("short", LMAC, PMAC, 16'h88B6, 1, p, 0, 0);
    check_val("plan.short_lat", last_latency, 24'h20);

    // Reset in the middle of a frame
    send_frame(LMAC, PMAC, 16'h88B6, make_payload(50, 0, PLEN), 0, 0, 30);
    do_reset();
    ts = 24'd500;
    run_frame("seq99", LMAC, PMAC, 16'h88B6, 1, make_payload(99, 32'd400, PLEN), 0, 0);
    check_val("plan.seq99", good_frames, 1);

    // Randomized frames
    for (int n = 0; n < 60; n++) begin
      int kind, len;
      logic [31:0] seq, txts;
      logic [TSW-1:0] lat;
      bit tu, en;
      logic [47:0] dm, sm;
      logic [15:0] et;
      kind = $urandom_range(0, 9);
      ts   = TSW'($urandom);
      lat  = TSW'($urandom_range(0, 5000));
      txts = {8'($urandom), ts - lat};
      seq  = m_exp_valid ? m_exp : $urandom;
      len  = PLEN; tu = 0; en = 1; dm = LMAC; sm = PMAC; et = 16'h88B6;
      case (kind)
        4: seq = seq + 32'($urandom_range(1, 5));
        6: begin len = $urandom_range(8, 80); if (len == PLEN) len = PLEN + 1; end
        7: len = $urandom_range(1, 7);
        8: tu = 1;
        9: case ($urandom_range(0, 3))
             0: et = ETH_TYPE_DATA;
             1: sm = PMAC ^ 48'h1;
             2: dm = LMAC ^ 48'h100;
             default: en = 0;
           endcase
        default: ;
      endcase
      p = make_payload(seq, txts, len);
      if (kind == 5) begin
        int b;
        b = $urandom_range(8, PLEN - 1);
        p[b] = p[b] ^ 8'(1 << $urandom_range(0, 7));
      end
      clr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b0;
      run_frame($sformatf("rand%0d", n), dm, sm, et, en, p, tu, clr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/eth_pattern_checker.md
Name: eth_pattern_checker

Overview:
- Receive-side test-pattern checker that sits directly downstream of the Ethernet frame receiver (eth_axis_rx); consumes its decoded header plus payload stream.
- Filters loopback test frames by MAC and ethertype, then checks each frame's sequence number, payload pattern and length.
- Measures round-trip latency against the free-running microsecond timestamp.
- Exposes saturating counters plus sticky, individually clearable error flags, for ILA and LED debug.

Parameters:
PAYLOAD_LENGTH, 56, expected payload bytes per frame, including the 8-byte info field; legal range 8..9000
ETH_TYPE, 16'h88B6, ethertype accepted as a test frame
TS_WIDTH, 24, timestamp and latency width in bits

Ports:
clk  in  1  system clock, 125 MHz
rst_n  in  1  synchronous reset, active-low
enable  in  1  checking enabled; frames are drained and ignored while low
local_mac  in  48  required dest MAC
peer_mac  in  48  required src MAC
timestamp  in  TS_WIDTH  free-running microsecond count
s_eth_hdr_valid  in  1  header valid
s_eth_hdr_ready  out  1  header ready
s_eth_dest_mac  in  48  header dest MAC
s_eth_src_mac  in  48  header src MAC
s_eth_type  in  16  header ethertype
s_eth_payload_axis_tdata  in  8  payload byte
s_eth_payload_axis_tvalid  in  1  payload valid
s_eth_payload_axis_tready  out  1  payload ready
s_eth_payload_axis_tlast  in  1  last payload byte
s_eth_payload_axis_tuser  in  1  frame bad, qualified with tlast
good_frames  out  32  count of error-free test frames
bad_frames  out  32  count of test frames with at least one error
dropped_frames  out  32  count of non-matching frames, or frames received while enable is low
last_latency  out  TS_WIDTH  latency of the most recent checked frame
max_latency  out  TS_WIDTH  largest latency seen since reset
error_flags  out  5  sticky flags: [0] pattern, [1] length, [2] sequence, [3] tuser, [4] short frame (<8 bytes)
error_clears  in  5  per-bit clear for error_flags

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; all counters, latencies and flags are 0.
  - s_eth_hdr_ready=0 during reset; expected-sequence register is invalid.
- Payload format, all fields big-endian:
  - bytes 0-3: seq[31:0].
  - bytes 4-7: tx timestamp; low TS_WIDTH bits used.
  - byte i, for i>=8: (seq[7:0]+i) mod 256.
- State machine:
  - IDLE: hdr_ready=1, tready=0. On hdr handshake, go to CHECK if enable && dest==local_mac && src==peer_mac && type==ETH_TYPE; otherwise go to DROP.
  - CHECK: tready=1, hdr_ready=0. Byte index counter (14 bits) increments on each beat. Bytes 0-7 are captured into registers; each byte >=8 is compared against the pattern. On the tlast beat, evaluate the frame and return to IDLE.
  - DROP: tready=1, hdr_ready=0. On the tlast beat, dropped_frames+1 and return to IDLE.
- Evaluation at tlast (total bytes = index+1):
  - Short frame: fewer than 8 bytes sets flag[4]. Sequence and latency are not evaluated.
  - Length: byte count != PAYLOAD_LENGTH sets flag[1].
  - Pattern: any mismatched byte in the frame sets flag[0].
  - tuser: tuser=1 on the tlast beat sets flag[3].
  - Sequence: if expected is valid and seq != expected, set flag[2]. Expected is then set to seq+1 (resync) and marked valid. The first frame after reset only initialises expected.
- Latency:
  - latency = (timestamp - tx_ts) mod 2^TS_WIDTH, sampled on the tlast beat; wrap-around is handled by the modular subtraction.
  - last_latency and max_latency update one cycle after tlast.
  - Latency updates only for frames that are neither short nor tuser-bad.
- Counters:
  - Exactly one of good_frames/bad_frames increments per CHECK frame, one cycle after tlast.
  - All counters saturate at all-ones.
- Flags:
  - An error event sets its flag. error_clears[k]=1 clears flag k.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- Frame truncation: tlast on any beat ends the frame; no timeout.
- enable falling mid-frame: the frame in CHECK completes and is evaluated normally.
- Reset mid-frame: the block returns to IDLE and the upstream stream stalls. Upstream shares this reset, so its stream is flushed too.

Decomposition:
- Shared package eth_test_pkg holds:
  - ETH_TYPE_TEST=16'h88B6 and ETH_TYPE_DATA=16'h88B5;
  - the payload info field offsets (SEQ_OFS=0, TS_OFS=4, INFO_LEN=8);
  - the error-flag bit indices;
  - the state encoding (IDLE/CHECK/DROP).
- One sub-module, sat_counter (width param, inc, out), instanced for the three frame counters.

Test Plan:
- Three frames with seq 5, 6, 7, PAYLOAD_LENGTH=56, correct pattern, tx_ts=timestamp-40 -> good_frames=3, flags=0, last_latency=40.
- Frames with seq 10 then seq 12 -> flag[2]=1, good=1, bad=1; a following frame with seq 13 counts as good.
- Byte 20 corrupted (expected (seq+20)&FF, sent XOR 1) -> flag[0]=1, bad+1; then error_clears=5'b00001 for 1 cycle -> flag[0]=0.
- Frames with the wrong ethertype 0x0800, a wrong src MAC, and one sent with enable=0 -> dropped_frames=3, good and bad unchanged, tready held high until tlast.
- tx_ts=0xFFFFF0 with timestamp=0x000010 at tlast -> last_latency=0x20. 6-byte frame -> flag[4], bad+1, latency unchanged.
- rst_n=0 asserted during byte 30 of a frame -> all outputs 0, IDLE. Next frame seq 99 -> good=1, no sequence error.
